// File: rtl/note_synth_pkg.sv
// note_synth_pkg: widths, guitar half-period table, mixer states and fret priority helper.
package note_synth_pkg;
    localparam int NUM_STRINGS = 6;
    localparam int NUM_FRETS = 5;
    localparam int HALF_W = 19;
    localparam int AMP_W = 16;
    localparam int ACC_W = 19;

    typedef enum logic [1:0] {IDLE, MIX, WRITE} mix_state_t;

    // round(25e6 / f) in clk cycles; rows E2 A2 D3 G3 B3 E4, columns frets 0..4
    localparam logic [HALF_W-1:0] HALF_PERIOD [NUM_STRINGS][NUM_FRETS] = '{
        '{19'd303373, 19'd286346, 19'd270274, 19'd255105, 19'd240787},
        '{19'd227273, 19'd214517, 19'd202477, 19'd191113, 19'd180386},
        '{19'd170262, 19'd160706, 19'd151686, 19'd143173, 19'd135137},
        '{19'd127553, 19'd120394, 19'd113636, 19'd107258, 19'd101238},
        '{19'd101238, 19'd95556,  19'd90193,  19'd85131,  19'd80353},
        '{19'd75843,  19'd71586,  19'd67569,  19'd63776,  19'd60197}
    };

    // {found, fret}: the highest fret pressed on string s wins
    function automatic logic [3:0] fret_sel(input logic [31:0] note, input int s);
        fret_sel = '0;
        for (int k = 0; k < NUM_FRETS; k++)
            if (note[6*k+s])
                fret_sel = {1'b1, 3'(k)};
    endfunction
endpackage

// File: rtl/note_synth_if.sv
// note_synth_if: note word from the recorder/player datapath and sample handshake to the codec.
interface note_synth_if;
    import note_synth_pkg::*;
    logic                   active;
    logic [31:0]            note_in;
    logic                   note_strobe;
    logic                   audio_out_allowed;
    logic                   write_audio_out;
    logic [23:0]            left_channel_audio_out;
    logic [23:0]            right_channel_audio_out;
    logic [NUM_STRINGS-1:0] voice_on;

    modport master (
        output active, note_in, note_strobe, audio_out_allowed,
        input  write_audio_out, left_channel_audio_out, right_channel_audio_out, voice_on
    );
    modport slave (
        input  active, note_in, note_strobe, audio_out_allowed,
        output write_audio_out, left_channel_audio_out, right_channel_audio_out, voice_on
    );
endinterface

// File: rtl/note_synth_voice.sv
// synth_voice: one string's square-wave oscillator with retrigger, gate-off and decaying amplitude.
module synth_voice
    import note_synth_pkg::*;
#(
    parameter logic [AMP_W-1:0] AMP_MAX = 16'd4000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_trig,
    input  logic              i_kill,
    input  logic              i_decay,
    input  logic [HALF_W-1:0] i_half,
    output logic [AMP_W-1:0]  o_amp,
    output logic              o_pol
);
    logic [HALF_W-1:0] r_half;
    logic [HALF_W-1:0] r_phase;
    logic [AMP_W-1:0]  r_amp;
    logic              r_pol;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_half <= '0;
            r_phase <= '0;
            r_amp <= '0;
            r_pol <= 1'b0;
        end else if (i_clear) begin
            r_amp <= '0;
        end else if (i_trig) begin
            r_amp <= AMP_MAX;
            r_phase <= i_half - HALF_W'(1);
            r_pol <= 1'b1;
            r_half <= i_half;
        end else if (i_kill) begin
            r_amp <= '0;
        end else if (r_amp != '0) begin
            if (r_phase == '0) begin
                r_phase <= r_half - HALF_W'(1);
                r_pol <= ~r_pol;
            end else begin
                r_phase <= r_phase - HALF_W'(1);
            end
            if (i_decay)
                r_amp <= (r_amp < AMP_W'(8)) ? '0 : r_amp - (r_amp >> 3);
        end
    end

    assign o_amp = r_amp;
    assign o_pol = r_pol;
endmodule

// File: rtl/note_synth.sv
// note_synth: six-string square-wave guitar synth mixed into signed 24-bit codec samples.
// NOTE_SYNTH_DECAY_EN adds the shared envelope decay; without it voices gate on each strobe.
module note_synth
    import note_synth_pkg::*;
#(
    parameter logic [AMP_W-1:0] AMP_MAX = 16'd4000,
`ifdef NOTE_SYNTH_DECAY_EN
    parameter int DECAY_TICKS = 2500000,
`endif
    parameter int GAIN_SHIFT = 4
) (
    input logic         clk,
    input logic         resetn,
    note_synth_if.slave bus
);
    logic                          w_strobe;
    logic                          w_decay;
    logic [NUM_STRINGS-1:0]        w_pol;
    logic [NUM_STRINGS-1:0]        w_on;
    logic [AMP_W-1:0]              w_amp [NUM_STRINGS];
    logic signed [ACC_W-1:0]       w_term;
    logic signed [23:0]            w_ext;
    mix_state_t                    r_state;
    logic [2:0]                    r_idx;
    logic signed [ACC_W-1:0]       r_acc;
    logic                          r_wr;
    logic [23:0]                   r_sample;

    assign w_strobe = bus.note_strobe & bus.active;

    for (genvar s = 0; s < NUM_STRINGS; s++) begin : g_voice
        logic [3:0] w_sel;
        logic       w_kill;
        assign w_sel = fret_sel(bus.note_in, s);
`ifdef NOTE_SYNTH_DECAY_EN
        assign w_kill = 1'b0;
`else
        assign w_kill = w_strobe & ~w_sel[3];
`endif
        synth_voice #(.AMP_MAX(AMP_MAX)) u_voice (
            .clk    (clk),
            .resetn (resetn),
            .i_clear(~bus.active),
            .i_trig (w_strobe & w_sel[3]),
            .i_kill (w_kill),
            .i_decay(w_decay),
            .i_half (HALF_PERIOD[s][w_sel[2:0]]),
            .o_amp  (w_amp[s]),
            .o_pol  (w_pol[s])
        );
        assign w_on[s] = w_amp[s] != '0;
    end

`ifdef NOTE_SYNTH_DECAY_EN
    localparam int DCNT_W = $clog2(DECAY_TICKS + 1);
    logic [DCNT_W-1:0] r_dcnt;
    assign w_decay = r_dcnt == DCNT_W'(DECAY_TICKS - 1);
    always_ff @(posedge clk)
        r_dcnt <= (!resetn || w_decay) ? '0 : r_dcnt + DCNT_W'(1);
`else
    assign w_decay = 1'b0;
`endif

    assign w_term = w_pol[r_idx] ? signed'(ACC_W'(w_amp[r_idx])) : -signed'(ACC_W'(w_amp[r_idx]));
    assign w_ext = 24'(r_acc);

    // one voice accumulated per MIX cycle; sample held in WRITE until the codec has room
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_acc <= '0;
            r_wr <= 1'b0;
            r_sample <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                IDLE: if (bus.audio_out_allowed) begin
                    r_acc <= '0;
                    r_idx <= '0;
                    r_state <= MIX;
                end
                MIX: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'(NUM_STRINGS - 1))
                        r_state <= WRITE;
                end
                WRITE: begin
                    r_sample <= w_ext << GAIN_SHIFT;
                    if (bus.audio_out_allowed) begin
                        r_wr <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.write_audio_out = r_wr;
    assign bus.left_channel_audio_out = r_sample;
    assign bus.right_channel_audio_out = r_sample;
    assign bus.voice_on = w_on;
endmodule

// File: tb/tb_note_synth.sv
// tb_note_synth: strike vector table, hand sequences and a randomized run checked every cycle
// against an event-level model of voices (strike time, half period, amplitude) and the mixer.
module tb_note_synth;
    localparam int AMP = 4000;
`ifdef NOTE_SYNTH_DECAY_EN
    localparam int T = 10;
`endif
    localparam int HT [6][5] = '{
        '{303373, 286346, 270274, 255105, 240787},
        '{227273, 214517, 202477, 191113, 180386},
        '{170262, 160706, 151686, 143173, 135137},
        '{127553, 120394, 113636, 107258, 101238},
        '{101238, 95556,  90193,  85131,  80353},
        '{75843,  71586,  67569,  63776,  60197}
    };

    typedef struct {
        logic [31:0] note;
        logic [5:0]  on;
        int          s;
        int          half;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    note_synth_if bus();

    note_synth #(
        .AMP_MAX(16'd4000),
`ifdef NOTE_SYNTH_DECAY_EN
        .DECAY_TICKS(T),
`endif
        .GAIN_SHIFT(4)
    ) u_dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    logic [18:0] dut_half [6];
    logic [18:0] dut_phase [6];
    logic [15:0] dut_amp [6];
    for (genvar g = 0; g < 6; g++) begin : g_peek
        assign dut_half[g] = u_dut.g_voice[g].u_voice.r_half;
        assign dut_phase[g] = u_dut.g_voice[g].u_voice.r_phase;
        assign dut_amp[g] = u_dut.g_voice[g].u_voice.r_amp;
    end

    int n_chk = 0;
    int n_fail = 0;
    int m_amp [6];
    int m_ts [6];
    int m_h [6];
    int en;
    int m_ph;
    int m_acc;
    int m_out;
    logic m_wr;
    vec_t vt [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fret_of(input logic [31:0] n, input int s);
        for (int k = 4; k >= 0; k--)
            if (n[6*k+s]) return k;
        return -1;
    endfunction

    // square wave starts high at the strike and flips every half period
    function automatic int contrib(input int s);
        if (m_amp[s] == 0) return 0;
        return (((en - m_ts[s]) / m_h[s]) % 2 == 0) ? m_amp[s] : -m_amp[s];
    endfunction

    function automatic logic [5:0] m_on();
        for (int s = 0; s < 6; s++) m_on[s] = m_amp[s] != 0;
    endfunction

    task automatic model_step();
        int f;
        if (!resetn) begin
            for (int s = 0; s < 6; s++) begin
                m_amp[s] = 0;
                m_ts[s] = 0;
                m_h[s] = 1;
            end
            en = 0; m_ph = 0; m_acc = 0; m_out = 0; m_wr = 1'b0;
            return;
        end
        m_wr = 1'b0;
        if (m_ph == 0) begin
            if (bus.audio_out_allowed) begin m_acc = 0; m_ph = 1; end
        end else if (m_ph <= 6) begin
            m_acc += contrib(m_ph - 1);
            m_ph++;
        end else begin
            m_out = m_acc * 16;
            if (bus.audio_out_allowed) begin m_wr = 1'b1; m_ph = 0; end
        end
        en++;
        for (int s = 0; s < 6; s++) begin
            f = fret_of(bus.note_in, s);
            if (!bus.active) m_amp[s] = 0;
            else if (bus.note_strobe && f >= 0) begin
                m_amp[s] = AMP;
                m_h[s] = HT[s][f];
                m_ts[s] = en;
            end
`ifdef NOTE_SYNTH_DECAY_EN
            else if (en % T == 0) m_amp[s] = (m_amp[s] < 8) ? 0 : m_amp[s] - m_amp[s] / 8;
`else
            else if (bus.note_strobe) m_amp[s] = 0;
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", {bus.write_audio_out, bus.left_channel_audio_out, bus.right_channel_audio_out, bus.voice_on},
              {m_wr, 24'(m_out), 24'(m_out), m_on()});
    endtask

    task automatic wait_write(input int budget);
        for (int i = 0; i < budget && !bus.write_audio_out; i++) cycle();
        check("write_seen", 64'(bus.write_audio_out), 64'd1);
    endtask

    task automatic strike(input logic [31:0] n);
        bus.note_in = n;
        bus.note_strobe = 1'b1;
        cycle();
        bus.note_strobe = 1'b0;
    endtask

    initial begin
        int writes;
        logic saw_neg;
        vt[0] = '{32'h0000_0001, 6'b000001, 0, 303373};
        vt[1] = '{32'h0000_2002, 6'b000010, 1, 202477};
        vt[2] = '{32'h0400_0100, 6'b000100, 2, 135137};
        vt[3] = '{32'h0020_0020, 6'b101000, 3, 107258};
        vt[4] = '{32'hC001_0000, 6'b010000, 4, 90193};
        vt[5] = '{32'h2000_003F, 6'b111111, 5, 60197};
        vt[6] = '{32'h0004_0040, 6'b000001, 0, 255105};
        vt[7] = '{32'h0000_0200, 6'b001000, 3, 120394};
        bus.active = 1'b0;
        bus.note_in = '0;
        bus.note_strobe = 1'b0;
        bus.audio_out_allowed = 1'b1;
        repeat (3) cycle();
        check("reset_out", {bus.write_audio_out, bus.left_channel_audio_out, bus.right_channel_audio_out, bus.voice_on}, '0);
        resetn = 1'b1;
        bus.active = 1'b1;
        repeat (4) cycle();

        foreach (vt[i]) begin
            bus.active = 1'b0;
            cycle();
            bus.active = 1'b1;
            strike(vt[i].note);
            check("vec_on", 64'(bus.voice_on), 64'(vt[i].on));
            check("vec_half", 64'(dut_half[vt[i].s]), 64'(vt[i].half));
            check("vec_phase", 64'(dut_phase[vt[i].s]), 64'(vt[i].half - 1));
            repeat (5) cycle();
            check("vec_phase5", 64'(dut_phase[vt[i].s]), 64'(vt[i].half - 6));
            repeat (6) cycle();
        end

`ifdef NOTE_SYNTH_DECAY_EN
        bus.active = 1'b0;
        cycle();
        bus.active = 1'b1;
        strike(32'h1);
        check("decay_0", 64'(dut_amp[0]), 64'd4000);
        repeat (10) cycle();
        check("decay_1", 64'(dut_amp[0]), 64'd3500);
        repeat (10) cycle();
        check("decay_2", 64'(dut_amp[0]), 64'd3063);
`else
        bus.active = 1'b0;
        cycle();
        bus.active = 1'b1;
        strike(32'h1);
        repeat (9) cycle();
        wait_write(10);
        check("open_sample", 64'(bus.left_channel_audio_out), 64'd64000);
        strike(32'h2);
        check("gate_on", 64'(bus.voice_on), 64'b000010);
        check("gate_amp0", 64'(dut_amp[0]), 64'd0);
        check("gate_amp1", 64'(dut_amp[1]), 64'd4000);
`endif

        strike(32'h1);
        repeat (3) cycle();
        bus.active = 1'b0;
        cycle();
        check("active_off", 64'(bus.voice_on), 64'd0);
        repeat (8) cycle();
        wait_write(10);
        check("silence", 64'(bus.left_channel_audio_out), 64'd0);
        bus.active = 1'b1;

        strike(32'h0000_2002);
        wait_write(10);
        cycle();
        bus.audio_out_allowed = 1'b0;
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            writes += int'(bus.write_audio_out);
        end
        check("hold_nowrite", 64'(writes), 64'd0);
        bus.audio_out_allowed = 1'b1;
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            writes += int'(bus.write_audio_out);
        end
        check("release_one", 64'(writes), 64'd1);

        wait_write(10);
        repeat (3) cycle();
        resetn = 1'b0;
        cycle();
        check("reset_mid", {bus.write_audio_out, bus.left_channel_audio_out}, '0);
        resetn = 1'b1;
        repeat (10) cycle();

        for (int i = 0; i < 3000; i++) begin
            bus.note_strobe = $urandom_range(0, 15) == 0;
            bus.note_in = $urandom & $urandom;
            bus.active = $urandom_range(0, 63) != 0;
            bus.audio_out_allowed = $urandom_range(0, 9) != 0;
            cycle();
        end
        bus.note_strobe = 1'b0;
        bus.active = 1'b1;
        bus.audio_out_allowed = 1'b1;

`ifndef NOTE_SYNTH_DECAY_EN
        strike(32'h2000_0000);
        saw_neg = 1'b0;
        for (int i = 0; i < 60300; i++) begin
            cycle();
            if (bus.write_audio_out && bus.left_channel_audio_out[23]) saw_neg = 1'b1;
        end
        check("toggle", 64'(saw_neg), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/note_synth.md
Name: note_synth

Overview:
- Downstream consumer of the recorder/player datapath's 32-bit note word.
- Turns each latched note into up to six square-wave guitar voices, one per string, each with a decaying envelope.
- Mixes the voices into one signed 24-bit sample and hands it to the audio codec controller through its allowed/write handshake.
- Sits between the recorder/player datapath and the audio codec controller.

Parameters:
- AMP_MAX, 16'd4000, voice amplitude on strike. Constraint: 6*AMP_MAX << GAIN_SHIFT < 2^23.
- GAIN_SHIFT, 4, left shift applied to the mixed sum.
- DECAY_TICKS, 2500000, clk cycles per envelope decay step (50 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous, active-low reset.
- active  in  1  high while playing or recording; low silences everything.
- note_in  in  32  note word. Bit 6k+s = string s at fret k (k=0 is open). Bits 31:30 ignored.
- note_strobe  in  1  one-cycle pulse per beat; latch note_in on this pulse.
- audio_out_allowed  in  1  codec FIFO has room.
- write_audio_out  out  1  one-cycle write pulse to the codec.
- left_channel_audio_out  out  24  signed sample.
- right_channel_audio_out  out  24  same value as left.
- voice_on  out  6  per-string flag, set when amp != 0.

Behaviour:
- Reset: all outputs 0; every voice has amp 0, polarity 0, phase 0; decay counter 0; FSM in IDLE.
- String mapping: string 0 = E2 (82.41 Hz) through string 5 = E4. Open frequencies are E2, A2, D3, G3, B3, E4; each fret adds one semitone.
- Half-period table: HALF[s][k] = round(25_000_000 / f). Values are 19-bit unsigned. Examples: HALF[0][0] = 303373, HALF[1][0] = 227273.
- Strobe handling: when note_strobe=1 and active=1, for each string s take the highest k with note_in[6k+s]=1 as its fret.
  - Fret found: retrigger the voice on the next cycle. amp <= AMP_MAX, phase <= HALF[s][k]-1, polarity <= 1, half-period register <= HALF[s][k]. Latency is 1 cycle.
  - No fret found: the voice keeps ringing and decaying untouched.
- Oscillator, per voice, every cycle while amp != 0:
  - phase == 0: reload HALF-1 and toggle polarity.
  - Otherwise: decrement phase.
- Envelope: a shared counter counts 0..DECAY_TICKS-1. On wrap, every voice updates:
  - amp < 8: amp <= 0.
  - Otherwise: amp <= amp - (amp >> 3).
  - A strobe and a decay wrap in the same cycle: the strobe wins for the retriggered voices.
- active=0: all amps cleared to 0 in the next cycle and strobes are ignored. The mixer keeps running and outputs zeros.
- Mixer FSM:
  - IDLE: when audio_out_allowed=1, clear acc and go to MIX.
  - MIX: 6 cycles. Cycle i adds +amp_i if polarity_i=1, else -amp_i. acc is 19-bit signed. Then go to WRITE.
  - WRITE: load both channel outputs with sign_extend24(acc) << GAIN_SHIFT.
    - If audio_out_allowed=1: pulse write_audio_out for exactly 1 cycle, then return to IDLE.
    - Otherwise: hold in WRITE with outputs stable.
  - Latency from allowed to write is 8 cycles.
  - Channel outputs hold their value between writes.
- resetn low mid-MIX or mid-WRITE: no write pulse; return to IDLE with outputs 0.

Optional Feature:
- Macro: NOTE_SYNTH_DECAY_EN.
- Defined: envelope decay as described above.
- Undefined: no decay counter. amp stays AMP_MAX until the next strobe. On a strobe, a string absent from note_in gets amp <= 0 immediately, which gives organ-style gating.

Decomposition:
- Package note_synth_pkg holds:
  - NUM_STRINGS=6, NUM_FRETS=5, HALF_W=19, AMP_W=16, ACC_W=19.
  - The HALF_PERIOD[6][5] constant table.
  - The mixer state enum: IDLE, MIX, WRITE.
- Sub-module synth_voice (one instance per string) holds phase counter, polarity, amp register, retrigger and decay inputs.
- The top level holds fret priority select, the decay counter and the mixer FSM.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, with audio_out_allowed=1 throughout. → write_audio_out=0, both channel outputs 0, voice_on=0.
- Single open string: active=1, note_in=32'h1, strobe, DECAY_TICKS=1e9. → voice_on=6'b000001. Polarity toggles every 303373 cycles. Written samples = +64000 / -64000.
- Fret priority: note_in bits 1 and 13 set (string 1, frets 0 and 2), strobe. → half-period 202477 (B2), voice_on=6'b000010.
- Handshake: drop audio_out_allowed during MIX. → FSM holds in WRITE with no pulse. Raise allowed → exactly one write pulse, then IDLE.
- Decay (macro on, DECAY_TICKS=10): strike → amp 4000, then 3500 after 10 cycles, then 3063. Drop active → amp 0 next cycle and the next written sample is 0.
- Macro off: strobe 32'h1, then strobe 32'h2. → voice 0 amp 0, voice 1 amp 4000, voice_on=6'b000010.
